// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode/status constants and the data-memory responder
// FSM state encoding.
package y86_pkg;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 4'd4;
   localparam logic [1:0] DMEM_IDLE   = 2'd0;
   localparam logic [1:0] DMEM_ACCESS = 2'd1;
   localparam logic [1:0] DMEM_RESP   = 2'd2;
   typedef enum logic [1:0] {
      DM_IDLE   = DMEM_IDLE,
      DM_ACCESS = DMEM_ACCESS,
      DM_RESP   = DMEM_RESP
   } dmem_state_e;
endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: single-port byte RAM, one synchronous read or write per
// cycle; read data holds until the next read.
module dmem_byte_array #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);
   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem_q[addr] <= wdata;
         else    rdata_q <= mem_q[addr];
      end
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: serves 8-byte little-endian memory requests one byte per cycle.
// Define DMEM_ALIGN_CHECK_EN to also reject addresses that are not 8-byte aligned.
module dmem_responder
   import y86_pkg::*;
#(
   parameter int MEM_BYTES = 4096,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);
   localparam int AW = $clog2(MEM_BYTES);
   dmem_state_e       state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              we_q, we_d, err_q, err_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [ADDR_W:0]   end_addr;
   logic              bad, ram_en, ram_we;
   logic [AW-1:0]     ram_addr;
   logic [7:0]        ram_wdata, ram_rdata;

   // 65-bit sum so addresses near 2^64 cannot wrap into range
   assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(8);
`ifdef DMEM_ALIGN_CHECK_EN
   assign bad = (end_addr > (ADDR_W+1)'(MEM_BYTES)) | (|req_addr[2:0]);
`else
   assign bad = end_addr > (ADDR_W+1)'(MEM_BYTES);
`endif

   assign req_ready = state_q == DM_IDLE;
   assign rsp_valid = state_q == DM_RESP;
   assign busy      = state_q != DM_IDLE;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = req_addr[AW-1:0];
      ram_wdata = wdata_q[8*cnt_q +: 8];
      case (state_q)
         DM_IDLE: if (req_valid) begin
            we_d    = req_we;
            addr_d  = req_addr[AW-1:0];
            wdata_d = req_wdata;
            rdata_d = '0;
            err_d   = bad;
            cnt_d   = 3'd0;
            state_d = bad ? DM_RESP : DM_ACCESS;
            // prefetch byte 0 so each ACCESS cycle captures the byte it owns
            ram_en  = ~bad & ~req_we;
         end
         DM_ACCESS: begin
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == 3'd7) ? DM_RESP : DM_ACCESS;
            if (we_q) begin
               ram_en   = 1'b1;
               ram_we   = 1'b1;
               ram_addr = addr_q + AW'(cnt_q);
            end else begin
               rdata_d[8*cnt_q +: 8] = ram_rdata;
               ram_en   = cnt_q != 3'd7;
               ram_addr = addr_q + AW'(cnt_q) + AW'(1);
            end
         end
         DM_RESP: state_d = rsp_ready ? DM_IDLE : DM_RESP;
         default: state_d = DM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DM_IDLE;
         cnt_q   <= 3'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   dmem_byte_array #(.DEPTH(MEM_BYTES), .AW(AW)) u_mem (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );
endmodule
